// File: rtl/cpu_debug_pkg.sv
// Shared debug-path definitions: dump FSM state encoding and register file geometry.
package cpu_debug_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int DATA_W_DEF   = 32;

    typedef logic [1:0] dump_state_t;

    localparam dump_state_t ST_IDLE = 2'd0;
    localparam dump_state_t ST_READ = 2'd1;
    localparam dump_state_t ST_SEND = 2'd2;
    localparam dump_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/dump_out_reg.sv
// Output holding register for the dump stream: captures data, index and last flag on load.
module dump_out_reg
    import cpu_debug_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic              last_i,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0] idx_o,
    output logic              last_o
);

    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] idx_q;
    logic              last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
        end else if (load_i) begin
            data_q <= data_i;
            idx_q  <= idx_i;
            last_q <= last_i;
        end
    end

    assign data_o = data_q;
    assign idx_o  = idx_q;
    assign last_o = last_q;

endmodule

// File: rtl/regfile_dump.sv
// Debug read-out engine: scans the register file through one read port and streams
// every value over valid/ready.
//
// state | meaning
// IDLE  | waiting for Start, index held at 0
// READ  | Reg_Addr = idx, read data captured into the output register
// SEND  | word presented, waiting for Out_Ready
// DONE  | one-cycle Done pulse, then back to IDLE
module regfile_dump
    import cpu_debug_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Start,
    input  logic              Abort,
    output logic [ADDR_W-1:0] Reg_Addr,
    input  logic [DATA_W-1:0] Reg_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Out_Data,
    output logic [ADDR_W-1:0] Out_Index,
    output logic              Out_Last,
    output logic              Busy,
    output logic              Done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              load;
    logic              handshake;

    assign handshake = Out_Valid && Out_Ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    idx_d   = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (Abort) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    load    = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // Abort beats a coincident handshake; the word is simply dropped from the stream.
                if (Abort) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else if (handshake) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    dump_out_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .data_i (Reg_Data),
        .idx_i  (idx_q),
        .last_i (idx_q == LAST_IDX),
        .data_o (Out_Data),
        .idx_o  (Out_Index),
        .last_o (Out_Last)
    );

    assign Reg_Addr  = idx_q;
    assign Out_Valid = (state_q == ST_SEND);
    assign Busy      = (state_q == ST_READ) || (state_q == ST_SEND);
    assign Done      = (state_q == ST_DONE);

endmodule
